// File: rtl/ed25519_pkg.sv
// Shared field-element constants, limb layout tables and types for the
// radix-2^25.5 representation of GF(2^255-19).
package ed25519_pkg;

   localparam int unsigned FE_LIMBS  = 10;
   localparam int unsigned FE_LIMB_W = 32;
   localparam int unsigned FE_BITS   = 255;
   localparam int unsigned ENC_BITS  = 256;
   localparam int unsigned FE_W      = FE_LIMBS * FE_LIMB_W;

   // Limb i covers encoding bits [LIMB_OFF[i] +: LIMB_WID[i]]
   localparam int unsigned LIMB_OFF [FE_LIMBS] = '{0, 26, 51, 77, 102, 128, 153, 179, 204, 230};
   localparam int unsigned LIMB_WID [FE_LIMBS] = '{26, 25, 26, 25, 26, 25, 26, 25, 26, 25};

   // p = 2^255 - 19 = 0x7fff...ffed
   localparam logic [FE_BITS-1:0] P_25519 = {{(FE_BITS-5){1'b1}}, 5'b01101};

   typedef logic [FE_W-1:0] fe_t;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_DONE = 1'b1
   } fe_fb_state_e;

   function automatic logic fe_ge_p(input logic [FE_BITS-1:0] v);
      return v >= P_25519;
   endfunction

endpackage

// File: rtl/fe_limb_unpack.sv
// Combinational split of a 255-bit little-endian value into ten
// zero-extended 32-bit limbs of alternating 26/25-bit width.
module fe_limb_unpack
   import ed25519_pkg::*;
(
   input  logic [FE_BITS-1:0] enc_i,
   output fe_t                fe_o
);

   for (genvar i = 0; i < FE_LIMBS; i++) begin : g_limb
      localparam int unsigned LO = LIMB_OFF[i];
      localparam int unsigned LW = LIMB_WID[i];
      assign fe_o[i*FE_LIMB_W +: FE_LIMB_W] = {{(FE_LIMB_W-LW){1'b0}}, enc_i[LO +: LW]};
   end

endmodule

// File: rtl/fe_frombytes_stream.sv
// Byte-serial to limb-parallel field-element decoder with valid/ready on both sides.
// Optional canonical-range flag is enabled by defining FE_FROMBYTES_CANON_CHECK_EN.
module fe_frombytes_stream
   import ed25519_pkg::*;
#(
   parameter int unsigned IN_W = 8
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [IN_W-1:0] in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [FE_W-1:0] h,
   output logic            out_valid,
   input  logic            out_ready,
`ifdef FE_FROMBYTES_CANON_CHECK_EN
   output logic            sign_bit,
   output logic            non_canonical
`else
   output logic            sign_bit
`endif
);

   localparam int unsigned BEATS = ENC_BITS / IN_W;
   localparam int unsigned CNT_W = $clog2(BEATS);
   localparam int unsigned SH_W  = $clog2(IN_W);

   fe_fb_state_e          state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [ENC_BITS-1:0]   buf_q;
   logic [ENC_BITS-1:0]   buf_d;
   logic                  in_ready_q;
   logic                  out_valid_q;
   fe_t                   h_q;
   fe_t                   fe_next;
   logic                  sign_q;
   logic                  accept_c;
   logic                  last_beat_c;

   assign accept_c    = (state_q == ST_LOAD) && in_ready_q && in_valid;
   assign last_beat_c = (cnt_q == CNT_W'(BEATS - 1));

   // Merge the incoming beat so the final beat reaches h on the same edge
   always_comb begin
      buf_d = buf_q;
      if (accept_c) begin
         buf_d[{cnt_q, SH_W'(0)} +: IN_W] = in_data;
      end
   end

   fe_limb_unpack u_unpack (
      .enc_i (buf_d[FE_BITS-1:0]),
      .fe_o  (fe_next)
   );

`ifdef FE_FROMBYTES_CANON_CHECK_EN
   logic non_canonical_q;
   assign non_canonical = non_canonical_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         non_canonical_q <= 1'b0;
      end else if (accept_c && last_beat_c) begin
         non_canonical_q <= fe_ge_p(buf_d[FE_BITS-1:0]);
      end
   end
`endif

   // Frame FSM: LOAD collects BEATS beats, DONE holds the result until taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         cnt_q       <= '0;
         buf_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         h_q         <= '0;
         sign_q      <= 1'b0;
      end else begin
         buf_q <= buf_d;
         case (state_q)
            ST_LOAD: begin
               in_ready_q <= 1'b1;
               if (accept_c) begin
                  if (last_beat_c) begin
                     cnt_q       <= '0;
                     state_q     <= ST_DONE;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     h_q         <= fe_next;
                     sign_q      <= buf_d[ENC_BITS-1];
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q     <= ST_LOAD;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_LOAD;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign h         = h_q;
   assign sign_bit  = sign_q;

endmodule

// File: tb/tb_fe_frombytes_stream.sv
// Self-checking bench for fe_frombytes_stream at IN_W = 8, 32 and 64, with
// an arithmetic reference model; FE_FROMBYTES_CANON_CHECK_EN adds range checks.
module tb_fe_frombytes_stream;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   din8  = '0;
   logic [31:0]  din32 = '0;
   logic [63:0]  din64 = '0;
   logic         vld  [3];
   logic         ordy [3];
   logic         rdy  [3];
   logic         ov   [3];
   logic         sgn  [3];
   logic [319:0] h_a  [3];
`ifdef FE_FROMBYTES_CANON_CHECK_EN
   logic         nc   [3];
`endif

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   fe_frombytes_stream #(.IN_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_data(din8), .in_valid(vld[0]), .in_ready(rdy[0]),
      .h(h_a[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
`ifdef FE_FROMBYTES_CANON_CHECK_EN
      .non_canonical(nc[0]),
`endif
      .sign_bit(sgn[0]));

   fe_frombytes_stream #(.IN_W(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_data(din32), .in_valid(vld[1]), .in_ready(rdy[1]),
      .h(h_a[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
`ifdef FE_FROMBYTES_CANON_CHECK_EN
      .non_canonical(nc[1]),
`endif
      .sign_bit(sgn[1]));

   fe_frombytes_stream #(.IN_W(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_data(din64), .in_valid(vld[2]), .in_ready(rdy[2]),
      .h(h_a[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
`ifdef FE_FROMBYTES_CANON_CHECK_EN
      .non_canonical(nc[2]),
`endif
      .sign_bit(sgn[2]));

   // Reference: limb i starts at ceil(25.5*i), width 26 for even i, 25 for odd
   function automatic logic [319:0] model_h(input logic [255:0] enc);
      logic [319:0] r;
      logic [255:0] sh;
      logic [31:0]  mask;
      r = '0;
      for (int i = 0; i < 10; i++) begin
         sh   = enc >> ((51 * i + 1) / 2);
         mask = (i % 2 == 0) ? 32'h03FF_FFFF : 32'h01FF_FFFF;
         r[i*32 +: 32] = sh[31:0] & mask;
      end
      return r;
   endfunction

   function automatic int width_of(input int sel);
      return (sel == 0) ? 8 : (sel == 1) ? 32 : 64;
   endfunction

   function automatic logic [255:0] rand_enc();
      logic [255:0] e;
      for (int i = 0; i < 8; i++) e[i*32 +: 32] = $urandom;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic [63:0] d, input logic v);
      case (sel)
         0:       din8  = d[7:0];
         1:       din32 = d[31:0];
         default: din64 = d;
      endcase
      vld[sel] = v;
   endtask

   // Push nbeats beats of enc; optional idle gaps carry junk data with in_valid=0
   task automatic send_frame(input int sel, input logic [255:0] enc, input int nbeats,
                             input bit gaps);
      int w, beats, t;
      logic [255:0] sh;
      w = width_of(sel);
      beats = 256 / w;
      for (int k = 0; k < nbeats; k++) begin
         if (gaps && $urandom_range(3) == 0) begin
            drive(sel, {$urandom, $urandom}, 1'b0);
            @(posedge clk); #1;
         end
         sh = enc >> (w * k);
         drive(sel, sh[63:0], 1'b1);
         t = 0;
         while (rdy[sel] !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
         end
         if (t >= 50) chk("in_ready_timeout", 320'(t), 320'd0);
         if (k == beats - 1) chk("out_valid_before_last", 320'(ov[sel]), 320'd0);
         @(posedge clk); #1;
         drive(sel, {$urandom, $urandom}, 1'b0);
      end
   endtask

   // Check the presented element, optionally stall the consumer, then take it
   task automatic recv(input int sel, input logic [255:0] enc, input int hold, input string tag);
      int t;
      logic [319:0] exp;
      exp = model_h(enc);
      t = 0;
      while (ov[sel] !== 1'b1 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk({tag, "_out_valid"}, 320'(ov[sel]), 320'd1);
      chk({tag, "_h"}, h_a[sel], exp);
      chk({tag, "_sign"}, 320'(sgn[sel]), 320'(enc[255]));
`ifdef FE_FROMBYTES_CANON_CHECK_EN
      chk({tag, "_noncanon"}, 320'(nc[sel]),
          320'({1'b0, enc[254:0]} >= ((256'd1 << 255) - 256'd19)));
`endif
      if (hold > 0) begin
         drive(sel, {$urandom, $urandom}, 1'b1);
         for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_h"}, h_a[sel], exp);
            chk({tag, "_hold_in_ready"}, 320'(rdy[sel]), 320'd0);
            chk({tag, "_hold_out_valid"}, 320'(ov[sel]), 320'd1);
         end
         drive(sel, 64'd0, 1'b0);
      end
      ordy[sel] = 1'b1;
      @(posedge clk); #1;
      ordy[sel] = 1'b0;
      chk({tag, "_drop_out_valid"}, 320'(ov[sel]), 320'd0);
      chk({tag, "_reload_in_ready"}, 320'(rdy[sel]), 320'd1);
   endtask

   task automatic frame(input int sel, input logic [255:0] enc, input int hold,
                        input bit gaps, input string tag);
      send_frame(sel, enc, 256 / width_of(sel), gaps);
      chk({tag, "_latency"}, 320'(ov[sel]), 320'd1);
      recv(sel, enc, hold, tag);
   endtask

   initial begin
      logic [255:0] e;
      logic [255:0] p_enc;
      p_enc = (256'd1 << 255) - 256'd19;
      for (int s = 0; s < 3; s++) begin
         vld[s]  = 1'b0;
         ordy[s] = 1'b0;
      end

      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         chk("rst_in_ready", 320'(rdy[s]), 320'd0);
         chk("rst_out_valid", 320'(ov[s]), 320'd0);
         chk("rst_h", h_a[s], 320'd0);
         chk("rst_sign", 320'(sgn[s]), 320'd0);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("first_in_ready", 320'(rdy[0]), 320'd1);

      frame(0, 256'd0, 0, 1'b0, "zero8");
      frame(0, 256'h01, 0, 1'b0, "one8");
      frame(0, 256'h0400_0000, 0, 1'b0, "two26_8");
      frame(0, {256{1'b1}}, 0, 1'b0, "allff8");
      frame(0, p_enc, 0, 1'b0, "p8");
      frame(0, p_enc - 256'd1, 0, 1'b0, "pm1_8");
      chk("pm1_limb0", 320'(h_a[0][31:0]), 320'h03FF_FFEC);

      frame(0, rand_enc(), 10, 1'b0, "stall8");
      frame(0, rand_enc(), 0, 1'b1, "after_stall8");
      for (int r = 0; r < 6; r++) frame(0, rand_enc(), r % 3, 1'b1, "rand8");

      send_frame(0, rand_enc(), 17, 1'b0);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", 320'(rdy[0]), 320'd0);
      chk("midrst_out_valid", 320'(ov[0]), 320'd0);
      chk("midrst_h", h_a[0], 320'd0);
      chk("midrst_sign", 320'(sgn[0]), 320'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      e = rand_enc();
      frame(0, e, 0, 1'b0, "post_rst8");

      for (int s = 1; s < 3; s++) begin
         frame(s, 256'd0, 0, 1'b0, "zero_w");
         frame(s, 256'h01, 0, 1'b0, "one_w");
         frame(s, {256{1'b1}}, 0, 1'b0, "allff_w");
         frame(s, rand_enc(), 4, 1'b1, "stall_w");
         for (int r = 0; r < 3; r++) frame(s, rand_enc(), 0, 1'b1, "rand_w");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
